fpu_multiplier: RTL
===================

# fpu_multiplier

Sequential radix-2 shift-and-add unsigned integer multiplier. It is the inverse companion of the restoring integer divider in the FPU datapath and produces the full double-width product used by mantissa multiplication. It uses the same start/done handshake as the divider, so one controller can drive both blocks. It computes one partial product per clock over WIDTH cycles.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2–32.
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low; `reset == 0` immediately forces the block to its reset state.
- `mulIn1`  in  WIDTH: multiplicand, unsigned; sampled only on the accepting edge.
- `mulIn2`  in  WIDTH: multiplier, unsigned; sampled only on the accepting edge.
- `start`  in  1: request a new multiply; honoured only in IDLE or DONE.
- `mulOut`  out  2*WIDTH: product `mulIn1 * mulIn2`; valid while `done == 1`.
- `done`  out  1: result valid; level signal held until the next accepted start or reset.
- `busy`  out  1: high while in CALC.

## Operation
- Internal registers:
  - `mcand` (WIDTH): latched multiplicand.
  - `acc` (2*WIDTH+1): upper WIDTH+1 bits hold the running partial sum including its carry bit; lower WIDTH bits start as the multiplier.
  - `count` (clog2(WIDTH)+1 bits).
- States:
  - IDLE: `done=0`, `busy=0`.
    - `start=1` → load `mcand=mulIn1`, `acc={(WIDTH+1)'0, mulIn2}`, `count=0` → CALC.
  - CALC: `busy=1`. Each edge performs one step:
    - If `acc[0]`, add `mcand` to `acc[2W:W]`; the carry goes into bit 2W.
    - Logical right shift of `acc` by 1.
    - `count++`.
    - When the step with `count==WIDTH-1` completes → DONE.
  - DONE: `done=1`, `mulOut=acc[2W-1:0]` (registered, stable).
    - `start=1` → same load as IDLE → CALC; `done` deasserts on that edge.
    - Otherwise hold.
- `start` in CALC is ignored. Operands are not re-sampled and the running result is unaffected.
- Operand changes outside the accepting edge have no effect.
- Arithmetic: all values are unsigned. The product always fits in 2*WIDTH bits, so there is no overflow flag. Zero operands need no special-casing.
- Reset values, asynchronous on `reset==0`:
  - state = IDLE;
  - `acc`, `mcand`, `count` = 0;
  - `mulOut = 0`, `done = 0`, `busy = 0`.
- Reset mid-CALC abandons the operation. No `done` pulse follows. After release the block waits in IDLE for a fresh start.

## Timing
- Accepting edge E (start=1 in IDLE/DONE): `busy=1` visible after E.
- Latency: exactly WIDTH CALC edges. `done=1` and `mulOut` valid after edge E+WIDTH; for WIDTH=8 that is 8 cycles after the start edge.
- `done` stays high indefinitely until the next accepted start or reset.
- Back-to-back throughput: start held high in DONE re-launches on the next edge. That gives one result per WIDTH+1 cycles.
- Outputs are purely registered; there are no combinational paths from inputs to `done`, `busy` or `mulOut`.

## Structure
- Shared package `fpu_pkg` holds:
  - `typedef enum logic [1:0] {MUL_IDLE, MUL_CALC, MUL_DONE} mulState_t`.
  - Any width helpers shared with the divider.
- Sub-module `fpu_mul_fsm`, instantiated as `FSM`:
  - Owns `currState`/`nextState` and `count`.
  - Emits `load`, `step`, `busy` and `done` to the datapath in the top module.
  - Keeps the split consistent with the divider so the benches can probe the states by hierarchy.

## Test plan
- WIDTH=8, 13 × 11 → `done` exactly 8 cycles after the start edge, `mulOut=143`.
- 255 × 255 → `mulOut=65025` (0xFE01), which checks that the top carry bit is kept; 0 × 200 → 0; 1 × 173 → 173.
- Pulse `start` again 3 cycles into a 7 × 9 operation with new operands 2 × 2 → result still 63 at the original time, and the second start is ignored.
- Assert `reset=0` 4 cycles into 100 × 100 → `busy`, `done` and `mulOut` drop to 0 at once; `done` stays 0 until a new start; then 6 × 7 → 42.
- From DONE, hold `start=1` with 3 × 5, then 10 × 10 → the first result is 15, `done` deasserts for 8 cycles, then the second result is 100.
- 100 random pairs (`$urandom` truncated to WIDTH): check `mulOut == a*b`. For each pair with nonzero operands, also feed the product's low half into `fpuDivider` as a cross-check where the product fits.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and width helpers for the multiplier and divider
package fpu_pkg;
   typedef enum logic [1:0] {MUL_IDLE, MUL_CALC, MUL_DONE} mulState_t;
   function automatic int cnt_bits(input int w);
      return $clog2(w) + 1;
   endfunction
endpackage

// File: rtl/fpu_multiplier_if.sv
// fpu_multiplier_if: operand/result bus with start/done handshake
interface fpu_multiplier_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0]   mulIn1;
   logic [WIDTH-1:0]   mulIn2;
   logic               start;
   logic [2*WIDTH-1:0] mulOut;
   logic               done;
   logic               busy;
   modport master (output mulIn1, mulIn2, start, input mulOut, done, busy);
   modport slave  (input mulIn1, mulIn2, start, output mulOut, done, busy);
endinterface

// File: rtl/fpu_mul_fsm.sv
// fpu_mul_fsm: IDLE/CALC/DONE sequencer and step counter for the multiplier
module fpu_mul_fsm
   import fpu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic start_i,
   output logic load_o,
   output logic step_o,
   output logic busy_o,
   output logic done_o
);
   localparam int CW = cnt_bits(WIDTH);
   mulState_t currState, nextState;
   logic [CW-1:0] count;
   logic busy_q, done_q;
   always_comb
      nextState = currState == MUL_CALC ? (count == CW'(WIDTH - 1) ? MUL_DONE : MUL_CALC)
                                        : (start_i ? MUL_CALC : currState);
   assign load_o = start_i && currState != MUL_CALC;
   assign step_o = currState == MUL_CALC;
   assign busy_o = busy_q;
   assign done_o = done_q;
   // busy/done are registered copies of the state being entered
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         currState <= MUL_IDLE;
         count     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         currState <= nextState;
         count     <= load_o ? '0 : step_o ? count + CW'(1) : count;
         busy_q    <= nextState == MUL_CALC;
         done_q    <= nextState == MUL_DONE;
      end
endmodule

// File: rtl/fpu_multiplier.sv
// fpu_multiplier: radix-2 shift-and-add unsigned multiplier, one partial product per clock
module fpu_multiplier #(
   parameter int WIDTH = 8
) (
   input logic             clock,
   input logic             reset,
   fpu_multiplier_if.slave bus
);
   logic load, step;
   logic [WIDTH-1:0] mcand_q;
   logic [2*WIDTH:0] acc_q, acc_d;
   logic [WIDTH:0]   sum;
   fpu_mul_fsm #(.WIDTH(WIDTH)) FSM (
      .clock(clock),
      .reset(reset),
      .start_i(bus.start),
      .load_o(load),
      .step_o(step),
      .busy_o(bus.busy),
      .done_o(bus.done)
   );
   // upper half never exceeds WIDTH bits before the add, so the carry lands in bit 2W
   assign sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
   assign bus.mulOut = acc_q[2*WIDTH-1:0];
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         mcand_q <= '0;
         acc_q   <= '0;
      end else if (load) begin
         mcand_q <= bus.mulIn1;
         acc_q   <= {{(WIDTH+1){1'b0}}, bus.mulIn2};
      end else if (step) begin
         acc_q   <= acc_d;
      end
endmodule
